// File: rtl/stupidrv_dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : stupidrv_dmem_bridge
// Purpose  : Bridges the stupidrv core's single-cycle, fixed-latency dmem_*
//            port onto a valid/ready request bus with a variable-latency
//            response. Drives the core's stall so load data is presented
//            exactly when the core samples it and only one access is ever
//            outstanding. An optional timeout aborts hung transactions and
//            raises a sticky error flag.
// Ports    :
//   clock, reset          - clock; synchronous active-high reset
//   dmem_valid/addr/
//   wstrb/wdata           - core data request (wstrb == 0 means read)
//   dmem_rdata            - load data returned to the core
//   stall                 - combinational core stall
//   bus_valid/ready       - bus request handshake
//   bus_addr/wstrb/wdata  - captured request fields, stable REQ..RESP
//   bus_rvalid/rdata      - bus response (reads and writes)
//   err                   - sticky timeout flag
// Params   : TIMEOUT - max cycles in REQ+RESP before abort (0 = disabled)
// Revision : 1.0 - initial release
// ============================================================================
module stupidrv_dmem_bridge #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        err
);

  localparam logic [1:0]  S_IDLE       = 2'd0;
  localparam logic [1:0]  S_REQ        = 2'd1;
  localparam logic [1:0]  S_RESP       = 2'd2;
  localparam logic        TIMEOUT_EN   = (TIMEOUT != 0);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  logic [1:0]  state_q,   state_d;
  logic        reset_q,   reset_d;
  logic        is_read_q, is_read_d;
  logic        consume_q, consume_d;
  logic [31:0] rdata_q,   rdata_d;
  logic [31:0] cnt_q,     cnt_d;
  logic        err_q,     err_d;
  logic [31:0] addr_q,    addr_d;
  logic [3:0]  wstrb_q,   wstrb_d;
  logic [31:0] wdata_q,   wdata_d;

  logic accept;
  logic busy;
  logic complete;
  logic abort;

  always_comb begin
    // The core does not execute during reset or the cycle after it, and in
    // the consume cycle any dmem_valid belongs to the instruction that is
    // still being written back, so none of those may start an access.
    accept   = (state_q == S_IDLE) && dmem_valid && !reset && !reset_q && !consume_q;
    busy     = (state_q == S_REQ) || (state_q == S_RESP);
    // bus_rvalid only counts once the request handshake has happened.
    complete = (state_q == S_RESP) && bus_rvalid;
    // A response arriving on the last allowed cycle wins over the abort.
    abort    = busy && !complete && TIMEOUT_EN && (cnt_q == TIMEOUT_LAST);

    reset_d   = reset;
    state_d   = state_q;
    is_read_d = is_read_q;
    consume_d = 1'b0;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;

    if (busy) begin
      cnt_d = cnt_q + 32'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d    = dmem_addr;
          wstrb_d   = dmem_wstrb;
          wdata_d   = dmem_wdata;
          is_read_d = (dmem_wstrb == 4'd0);
          cnt_d     = 32'd0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (bus_ready) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (complete || abort) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Reads always hand the core a value, even on abort, so the pipeline
    // resumes with deterministic data (zero) instead of hanging.
    if (complete && is_read_q) begin
      rdata_d   = bus_rdata;
      consume_d = 1'b1;
    end
    if (abort) begin
      err_d = 1'b1;
      if (is_read_q) begin
        rdata_d   = 32'd0;
        consume_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    reset_q <= reset_d;
    if (reset) begin
      state_q   <= S_IDLE;
      is_read_q <= 1'b0;
      consume_q <= 1'b0;
      rdata_q   <= 32'd0;
      cnt_q     <= 32'd0;
      err_q     <= 1'b0;
      addr_q    <= 32'd0;
      wstrb_q   <= 4'd0;
      wdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      is_read_q <= is_read_d;
      consume_q <= consume_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
    end
  end

  // Stores are posted: only stall for a store when the core already wants
  // the next access; loads stall until their data is in rdata_q.
  assign stall      = (state_q != S_IDLE) && (is_read_q || dmem_valid);
  assign bus_valid  = (state_q == S_REQ);
  assign bus_addr   = addr_q;
  assign bus_wstrb  = wstrb_q;
  assign bus_wdata  = wdata_q;
  assign dmem_rdata = rdata_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_stupidrv_dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_stupidrv_dmem_bridge
// Purpose  : Self-checking bench for stupidrv_dmem_bridge (TIMEOUT = 8).
//            A transaction-level model of the bridge predicts every output
//            each cycle; directed scenarios add hand-computed expectations,
//            followed by a randomized core/bus/reset phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stupidrv_dmem_bridge;

  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        dmem_valid;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        err;

  always #5 clock = ~clock;

  stupidrv_dmem_bridge #(.TIMEOUT(TO)) dut (
    .clock      (clock),
    .reset      (reset),
    .dmem_valid (dmem_valid),
    .dmem_addr  (dmem_addr),
    .dmem_wstrb (dmem_wstrb),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .stall      (stall),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .bus_addr   (bus_addr),
    .bus_wstrb  (bus_wstrb),
    .bus_wdata  (bus_wdata),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .err        (err)
  );

  int n_checks = 0;
  int n_err    = 0;
  int stall_cnt;

  // Inputs for the next cycle; applied at the following negedge.
  logic        nx_rst, nx_v, nx_rdy, nx_rv;
  logic [31:0] nx_a, nx_wd, nx_rd;
  logic [3:0]  nx_ws;

  // Transaction-level model: one outstanding access, how long it has been
  // outstanding, whether the bus has taken the request, and what the core sees.
  bit          m_busy, m_acc, m_read, m_consume, m_err, m_rst_prev;
  int          m_age;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;

  logic [31:0] hs_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic core(input logic v, input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd);
    nx_v = v; nx_a = a; nx_ws = ws; nx_wd = wd;
  endtask

  task automatic bus(input logic rdy, input logic rv, input logic [31:0] rd);
    nx_rdy = rdy; nx_rv = rv; nx_rd = rd;
  endtask

  task automatic tick();
    bit e_bv, e_st, cmpl, nx_cons;
    @(negedge clock);
    reset = nx_rst; dmem_valid = nx_v; dmem_addr = nx_a; dmem_wstrb = nx_ws;
    dmem_wdata = nx_wd; bus_ready = nx_rdy; bus_rvalid = nx_rv; bus_rdata = nx_rd;
    #1;
    e_bv = m_busy && !m_acc;
    e_st = m_busy && (m_read || nx_v);
    chk("bus_valid",  32'(bus_valid), 32'(e_bv));
    chk("stall",      32'(stall),     32'(e_st));
    chk("err",        32'(err),       32'(m_err));
    chk("dmem_rdata", dmem_rdata,     m_rdata);
    if (e_bv) begin
      chk("bus_addr",  bus_addr,         m_addr);
      chk("bus_wstrb", 32'(bus_wstrb),   32'(m_wstrb));
      chk("bus_wdata", bus_wdata,        m_wdata);
    end
    if (bus_valid && bus_ready) hs_q.push_back(bus_addr);
    // advance the model to the state after the coming clock edge
    nx_cons = 1'b0;
    if (nx_rst) begin
      m_busy = 0; m_acc = 0; m_read = 0; m_err = 0; m_rdata = 32'd0; m_rst_prev = 1;
    end else begin
      if (m_busy) begin
        m_age++;
        cmpl = 1'b0;
        if (!m_acc) m_acc = nx_rdy;
        else if (nx_rv) cmpl = 1'b1;
        if (cmpl || (TO != 0 && m_age == TO)) begin
          if (!cmpl) m_err = 1;
          if (m_read) begin
            m_rdata = cmpl ? nx_rd : 32'd0;
            nx_cons = 1'b1;
          end
          m_busy = 0;
        end
      end else if (nx_v && !m_rst_prev && !m_consume) begin
        m_busy = 1; m_acc = 0; m_age = 0; m_read = (nx_ws == 4'd0);
        m_addr = nx_a; m_wstrb = nx_ws; m_wdata = nx_wd;
      end
      m_rst_prev = 0;
    end
    m_consume = nx_cons;
  endtask

  initial begin
    reset = 1'b1; dmem_valid = 1'b0; dmem_addr = '0; dmem_wstrb = '0; dmem_wdata = '0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    m_busy = 0; m_acc = 0; m_read = 0; m_consume = 0; m_err = 0; m_rst_prev = 1;
    m_age = 0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_wstrb = '0;
    nx_rst = 1'b1; core(0, 0, 0, 0); bus(0, 0, 0);

    // ---- reset state, then a request during the reset_q cycle ----
    tick(); tick();
    chk("rst_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_stall",     32'(stall),     32'd0);
    chk("rst_err",       32'(err),       32'd0);
    chk("rst_rdata",     dmem_rdata,     32'd0);
    nx_rst = 1'b0; core(1, 32'h80, 4'h0, 0); tick();
    core(0, 0, 0, 0); tick();
    chk("rstq_no_accept", 32'(bus_valid), 32'd0);

    // ---- load, zero-wait bus ----
    hs_q.delete();
    core(1, 32'h100, 4'h0, 0); bus(0, 0, 0); tick();
    chk("ld_accept_stall", 32'(stall), 32'd0);
    bus(1, 0, 0); tick();
    chk("ld_req_valid", 32'(bus_valid), 32'd1);
    chk("ld_req_addr",  bus_addr,       32'h100);
    chk("ld_stall1",    32'(stall),     32'd1);
    bus(0, 1, 32'hDEADBEEF); tick();
    chk("ld_stall2",    32'(stall),     32'd1);
    bus(0, 0, 0); tick();
    chk("ld_stall3",    32'(stall),     32'd0);
    chk("ld_rdata",     dmem_rdata,     32'hDEADBEEF);
    core(0, 0, 0, 0); tick();
    chk("ld_consume_no_accept", 32'(bus_valid), 32'd0);
    chk("ld_reqs", 32'(hs_q.size()), 32'd1);

    // ---- wait states: ready withheld 3 cycles, rvalid 2 cycles after ready ----
    hs_q.delete(); stall_cnt = 0;
    core(1, 32'h300, 4'h0, 0); bus(0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      tick(); stall_cnt += int'(stall);
      chk("ws_valid", 32'(bus_valid), 32'd1);
      chk("ws_addr",  bus_addr,       32'h300);
    end
    bus(1, 0, 0); tick(); stall_cnt += int'(stall);
    chk("ws_addr_hs", bus_addr, 32'h300);
    bus(0, 0, 0); tick(); stall_cnt += int'(stall);
    bus(0, 1, 32'hCAFEF00D); tick(); stall_cnt += int'(stall);
    core(0, 0, 0, 0); bus(0, 0, 0); tick(); stall_cnt += int'(stall);
    chk("ws_stall_cycles", 32'(stall_cnt),    32'd6);
    chk("ws_reqs",         32'(hs_q.size()),  32'd1);
    chk("ws_rdata",        dmem_rdata,        32'hCAFEF00D);

    // ---- posted store followed by ALU ops ----
    hs_q.delete(); stall_cnt = 0;
    core(1, 32'h200, 4'hF, 32'h12345678); bus(0, 0, 0); tick(); stall_cnt += int'(stall);
    core(0, 0, 0, 0); bus(1, 0, 0); tick(); stall_cnt += int'(stall);
    chk("st_addr",  bus_addr,        32'h200);
    chk("st_wstrb", 32'(bus_wstrb),  32'hF);
    chk("st_wdata", bus_wdata,       32'h12345678);
    bus(0, 0, 0);
    for (int i = 0; i < 3; i++) begin tick(); stall_cnt += int'(stall); end
    bus(0, 1, 0); tick(); stall_cnt += int'(stall);
    bus(0, 0, 0); tick(); stall_cnt += int'(stall);
    chk("st_stall_cycles", 32'(stall_cnt),   32'd0);
    chk("st_reqs",         32'(hs_q.size()), 32'd1);

    // ---- store immediately followed by a load ----
    hs_q.delete();
    core(1, 32'h204, 4'hF, 32'hA5A5A5A5); bus(0, 0, 0); tick();
    core(1, 32'h208, 4'h0, 0); bus(1, 0, 0); tick();
    chk("sl_stall_req", 32'(stall), 32'd1);
    bus(0, 0, 0); tick();
    chk("sl_stall_resp", 32'(stall), 32'd1);
    bus(0, 1, 0); tick();
    chk("sl_stall_rv", 32'(stall), 32'd1);
    bus(0, 0, 0); tick();
    chk("sl_idle_stall", 32'(stall), 32'd0);
    bus(1, 0, 0); tick();
    chk("sl_ld_valid", 32'(bus_valid), 32'd1);
    chk("sl_ld_addr",  bus_addr,       32'h208);
    core(0, 0, 0, 0); bus(0, 1, 32'h0BADF00D); tick();
    bus(0, 0, 0); tick();
    chk("sl_rdata", dmem_rdata, 32'h0BADF00D);
    chk("sl_reqs",  32'(hs_q.size()), 32'd2);
    if (hs_q.size() == 2) begin
      chk("sl_order0", hs_q[0], 32'h204);
      chk("sl_order1", hs_q[1], 32'h208);
    end

    // ---- timeout on a load with a silent bus ----
    core(1, 32'h400, 4'h0, 0); bus(0, 0, 0); tick();
    core(0, 0, 0, 0); stall_cnt = 0;
    for (int i = 0; i < TO; i++) begin tick(); stall_cnt += int'(stall); end
    chk("to_stall_cycles", 32'(stall_cnt), 32'd8);
    bus(0, 1, 32'hBAD0BAD0); tick();
    chk("to_err",    32'(err),       32'd1);
    chk("to_rdata",  dmem_rdata,     32'd0);
    chk("to_stall",  32'(stall),     32'd0);
    chk("to_idle",   32'(bus_valid), 32'd0);
    bus(0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("to_err_sticky",  32'(err),   32'd1);
    chk("to_late_ignored", dmem_rdata, 32'd0);

    // ---- reset while in RESP ----
    core(1, 32'h500, 4'h0, 0); bus(0, 0, 0); tick();
    bus(1, 0, 0); tick();
    nx_rst = 1'b1; bus(0, 0, 0); tick();
    nx_rst = 1'b0; core(1, 32'h504, 4'h0, 0); tick();
    chk("rr_valid",       32'(bus_valid), 32'd0);
    chk("rr_stall",       32'(stall),     32'd0);
    chk("rr_err_cleared", 32'(err),       32'd0);
    tick();
    chk("rr_no_accept_rq", 32'(bus_valid), 32'd0);
    core(0, 0, 0, 0); tick();
    chk("rr_accept_after", 32'(bus_valid), 32'd1);
    chk("rr_accept_addr",  bus_addr,       32'h504);

    // ---- randomized core, bus and reset activity ----
    for (int c = 0; c < 4000; c++) begin
      nx_rst = ($urandom_range(0, 199) == 0);
      nx_v   = ($urandom_range(0, 1) == 1);
      nx_a   = $urandom;
      nx_ws  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      nx_wd  = $urandom;
      if (m_busy && !m_acc) nx_rdy = ($urandom_range(0, 3) == 0);
      else                  nx_rdy = ($urandom_range(0, 7) == 0);
      if (m_busy && m_acc)  nx_rv  = ($urandom_range(0, 3) == 0);
      else                  nx_rv  = ($urandom_range(0, 15) == 0);
      nx_rd  = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
